if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the five-stage pipeline, sitting directly upstream of the IF/ID pipeline register. It owns the program counter, selects the next PC (sequential, branch, jump), issues fetches to the instruction cache over a request/ready handshake, and presents `pc_4`/`ins` to IF/ID. It also raises a miss-stall indication while the cache is filling, and discards any fetch made stale by a redirect that arrives during a miss.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `NOP_INS`, 32'h0000_0000, instruction word driven when output is invalid

- `clk`  in  1  pipeline clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `stall`  in  1  hazard-unit hold; PC keeps its value
- `branch_taken`  in  1  branch resolved taken this cycle
- `branch_target`  in  32  branch destination
- `jump`  in  1  jump decoded this cycle
- `jump_target`  in  32  jump destination
- `icache_req`  out  1  fetch request
- `icache_addr`  out  32  fetch address (word aligned)
- `icache_rdata`  in  32  instruction word, valid when `icache_ready`=1
- `icache_ready`  in  1  same-cycle completion of the current request
- `pc_4`  out  32  fetched PC + 4, to IF/ID
- `ins`  out  32  fetched instruction, to IF/ID
- `if_valid`  out  1  `ins`/`pc_4` hold a real, non-stale fetch
- `miss_stall`  out  1  fetch outstanding, not completed; freeze PC and IF/ID

## Operation
- FSM states: FETCH, DISCARD.
- Redirect = `branch_taken | jump`. Target = `branch_target` if `branch_taken`, else `jump_target`. Branch wins on simultaneous assertion.
- FETCH:
  - Drive `icache_req`=1 and `icache_addr`=pc.
  - ready=1:
    - Drive `ins`=rdata, `pc_4`=pc+4, `if_valid`=1.
    - Next pc, in priority order: redirect → target; `stall` → pc; else pc+4.
  - ready=0:
    - Drive `if_valid`=0, `ins`=NOP_INS, `miss_stall`=1; pc held.
    - On redirect: latch target into `pend_pc`, go to DISCARD.
- DISCARD:
  - Keep `icache_req`=1 with `icache_addr`=old pc until ready; `if_valid`=0, `ins`=NOP_INS, `miss_stall`=1.
  - A further redirect overwrites `pend_pc`; branch priority still applies.
  - When ready=1: pc←`pend_pc` (a same-cycle redirect's target wins over `pend_pc`); go to FETCH. The returned data is dropped.
- `stall` never aborts a cache request. It only holds pc on completion.
- A redirect in FETCH with ready=1 still outputs the fetched word as valid. Squashing it is IF/ID's job via its flush input.
- pc+4 wraps modulo 2^32. Targets are used as given. Bits [1:0] of `icache_addr` are forced to 0.

## Timing
- While `rst` is low:
  - pc=RESET_PC, state=FETCH, `icache_req`=0, `if_valid`=0, `miss_stall`=0, `ins`=NOP_INS, `pc_4`=RESET_PC+4, `pend_pc`=0.
- First request goes out in the first cycle after `rst` deasserts.
- Hit latency is zero cycles: `ins` is combinational from `icache_rdata` in the cycle `icache_addr` is presented. PC advances on the next edge.
- A miss of N wait cycles produces N cycles of `miss_stall`=1/`if_valid`=0, then one valid cycle.
- The request is held stable (address unchanged, `icache_req` high) until `icache_ready`. The cache may rely on this.
- Reset asserted mid-miss or in DISCARD returns to the reset state immediately. The pending fetch is abandoned, and the cache must tolerate a dropped request.

## Structure
- Shared pipeline package holds:
  - `NOP_INS` and `RESET_PC` defaults.
  - FSM state typedef (FETCH=1'b0, DISCARD=1'b1).
  - 32-bit word/address typedef, shared with IF/ID and ID.
- One natural sub-module: `if_next_pc`, a combinational next-PC select (redirect priority, stall hold, +4).
- The parent holds the pc register, the `pend_pc` register and the FSM.

## Test plan
- Reset release, cache always ready: PCs 0,4,8,C issued on consecutive cycles; `pc_4`=4,8,C,10; `if_valid`=1 each cycle.
- Miss at pc=8, ready after 3 cycles, rdata=32'h00000824: `icache_addr` held at 8 for 4 cycles with `miss_stall`=1 for 3; then `ins`=32'h00000824, `pc_4`=C; next pc=C.
- Redirect during miss: at pc=10, ready=0, `branch_taken`=1 with target 40. Enter DISCARD, never `if_valid`; after ready the next address is 40, then 44.
- Simultaneous `branch_taken` (target 80) and `jump` (target 100) on a hit at pc=20: next address 80.
- `stall`=1 for 2 cycles with hits at pc=30: address stays 30 for 3 cycles, `if_valid`=1 throughout; then 34.
- Reset asserted mid-miss (pc=50): outputs reach reset values immediately; after release the first address is RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and its IF/ID and ID neighbours.
package if_fetch_stage_pkg;

    typedef logic [31:0] word_t;

    localparam word_t RESET_PC = 32'h0000_0000;
    localparam word_t NOP_INS  = 32'h0000_0000;

    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_e;

    // Instruction-cache request as seen on the fetch port.
    typedef struct packed {
        logic  req;
        word_t addr;
    } icache_req_t;

    // The cache is word addressed; low address bits are never presented.
    function automatic word_t align_word(input word_t a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_next_pc.sv
// Combinational next-PC select: redirect target, then pending target, then stall hold, then pc+4.
module if_next_pc
    import if_fetch_stage_pkg::*;
(
    input  word_t pc,
    input  word_t pend_pc,
    input  logic  discard,
    input  logic  stall,
    input  logic  branch_taken,
    input  word_t branch_target,
    input  logic  jump,
    input  word_t jump_target,
    output logic  redirect,
    output word_t target,
    output word_t pc_plus4,
    output word_t next_pc
);

    // Branch beats jump; a live redirect beats a stored one; stall only matters for sequential flow.
    always_comb begin
        redirect = branch_taken | jump;
        target   = branch_taken ? branch_target : jump_target;
        pc_plus4 = pc + 32'd4;
        if (redirect)
            next_pc = target;
        else if (discard)
            next_pc = pend_pc;
        else if (stall)
            next_pc = pc;
        else
            next_pc = pc_plus4;
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, drives the icache handshake, and drops fetches
// made stale by a redirect that lands while a miss is outstanding.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic [31:0] icache_rdata,
    input  logic        icache_ready,
    output logic [31:0] pc_4,
    output logic [31:0] ins,
    output logic        if_valid,
    output logic        miss_stall
);

    fetch_state_e state, state_nx;
    word_t        pc, pend_pc;
    word_t        next_pc, target, pc_plus4;
    logic         redirect;
    icache_req_t  fetch_req;

    if_next_pc u_next_pc (
        .pc            (pc),
        .pend_pc       (pend_pc),
        .discard       (state == DISCARD),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .redirect      (redirect),
        .target        (target),
        .pc_plus4      (pc_plus4),
        .next_pc       (next_pc)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= FETCH;
        else
            state <= state_nx;
    end

    // PC advances only when the cache completes; a redirect seen mid-miss is parked in pend_pc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_PC;
            pend_pc <= '0;
        end else begin
            if (icache_ready)
                pc <= next_pc;
            if (!icache_ready && redirect)
                pend_pc <= target;
        end
    end

    // Next state and handshake/IF-ID outputs; reset forces everything quiet combinationally.
    always_comb begin
        state_nx       = state;
        fetch_req.req  = 1'b1;
        fetch_req.addr = align_word(pc);
        if_valid       = 1'b0;
        miss_stall     = 1'b0;
        ins            = NOP_INS;
        case (state)
            FETCH: begin
                if (icache_ready) begin
                    ins      = icache_rdata;
                    if_valid = 1'b1;
                end else begin
                    miss_stall = 1'b1;
                    if (redirect)
                        state_nx = DISCARD;
                end
            end
            DISCARD: begin
                // The returned word belongs to the abandoned path and is dropped.
                miss_stall = 1'b1;
                if (icache_ready)
                    state_nx = FETCH;
            end
            default: state_nx = FETCH;
        endcase
        if (!rst) begin
            fetch_req.req = 1'b0;
            if_valid      = 1'b0;
            miss_stall    = 1'b0;
            ins           = NOP_INS;
        end
    end

    assign icache_req  = fetch_req.req;
    assign icache_addr = fetch_req.addr;
    assign pc_4        = pc_plus4;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Table-driven bench for if_fetch_stage with an expected-value scoreboard queue.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, branch_taken, jump, icache_ready;
    logic [31:0] branch_target, jump_target, icache_rdata;
    logic        icache_req, if_valid, miss_stall;
    logic [31:0] icache_addr, pc_4, ins;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rdy;
        logic [31:0] rd;
        logic        stl;
        logic        bt;
        logic [31:0] btg;
        logic        jp;
        logic [31:0] jtg;
        logic [31:0] e_addr;
        logic        e_vld;
        logic        e_ms;
        logic [31:0] e_ins;
        logic [31:0] e_pc4;
        logic        chk_ms;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    if_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .icache_req    (icache_req),
        .icache_addr   (icache_addr),
        .icache_rdata  (icache_rdata),
        .icache_ready  (icache_ready),
        .pc_4          (pc_4),
        .ins           (ins),
        .if_valid      (if_valid),
        .miss_stall    (miss_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic add(input logic rdy, input logic [31:0] rd, input logic stl,
                       input logic bt, input logic [31:0] btg, input logic jp, input logic [31:0] jtg,
                       input logic [31:0] e_addr, input logic e_vld, input logic e_ms,
                       input logic [31:0] e_ins, input logic [31:0] e_pc4, input logic chk_ms);
        vec_t v;
        v.rdy = rdy; v.rd = rd; v.stl = stl; v.bt = bt; v.btg = btg; v.jp = jp; v.jtg = jtg;
        v.e_addr = e_addr; v.e_vld = e_vld; v.e_ms = e_ms; v.e_ins = e_ins; v.e_pc4 = e_pc4;
        v.chk_ms = chk_ms;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        icache_ready  = v.rdy;
        icache_rdata  = v.rd;
        stall         = v.stl;
        branch_taken  = v.bt;
        branch_target = v.btg;
        jump          = v.jp;
        jump_target   = v.jtg;
        exp_q.push_back(v);
    endtask

    task automatic compare(input int idx);
        vec_t e;
        string s;
        e = exp_q.pop_front();
        s = $sformatf("row%0d", idx);
        chk({s, " req"},  {31'd0, icache_req}, 32'd1);
        chk({s, " addr"}, icache_addr, e.e_addr);
        chk({s, " vld"},  {31'd0, if_valid}, {31'd0, e.e_vld});
        chk({s, " ins"},  ins, e.e_ins);
        if (e.chk_ms) chk({s, " ms"}, {31'd0, miss_stall}, {31'd0, e.e_ms});
        if (e.e_vld)  chk({s, " pc4"}, pc_4, e.e_pc4);
    endtask

    initial begin
        // rdy rdata stl bt btg jp jtg | addr vld ms ins pc4 chk_ms
        // Straight-line hits from reset; a jump at C revisits 8.
        add(1, 32'h11, 0, 0, 0, 0, 0,   32'h00, 1, 0, 32'h11, 32'h04, 1);
        add(1, 32'h12, 0, 0, 0, 0, 0,   32'h04, 1, 0, 32'h12, 32'h08, 1);
        add(1, 32'h13, 0, 0, 0, 0, 0,   32'h08, 1, 0, 32'h13, 32'h0C, 1);
        add(1, 32'h14, 0, 0, 0, 1, 8,   32'h0C, 1, 0, 32'h14, 32'h10, 1);
        // Miss at 8, three wait cycles.
        add(0, 32'hDEAD, 0, 0, 0, 0, 0, 32'h08, 0, 1, 32'h0, 0, 1);
        add(0, 32'hDEAD, 0, 0, 0, 0, 0, 32'h08, 0, 1, 32'h0, 0, 1);
        add(0, 32'hDEAD, 0, 0, 0, 0, 0, 32'h08, 0, 1, 32'h0, 0, 1);
        add(1, 32'h824, 0, 0, 0, 0, 0,  32'h08, 1, 0, 32'h824, 32'h0C, 1);
        add(1, 32'h15, 0, 0, 0, 1, 32'h10, 32'h0C, 1, 0, 32'h15, 32'h10, 1);
        // Redirect during miss at 10 -> DISCARD, then 40, 44.
        add(0, 32'hDEAD, 0, 1, 32'h40, 0, 0, 32'h10, 0, 1, 32'h0, 0, 1);
        add(0, 32'hDEAD, 0, 0, 0, 0, 0, 32'h10, 0, 1, 32'h0, 0, 1);
        add(1, 32'h99, 0, 0, 0, 0, 0,   32'h10, 0, 1, 32'h0, 0, 0);
        add(1, 32'h16, 0, 0, 0, 0, 0,   32'h40, 1, 0, 32'h16, 32'h44, 1);
        add(1, 32'h17, 0, 0, 0, 1, 32'h20, 32'h44, 1, 0, 32'h17, 32'h48, 1);
        // Branch and jump together: branch wins.
        add(1, 32'h18, 0, 1, 32'h80, 1, 32'h100, 32'h20, 1, 0, 32'h18, 32'h24, 1);
        add(1, 32'h19, 0, 0, 0, 1, 32'h30, 32'h80, 1, 0, 32'h19, 32'h84, 1);
        // Stall two cycles on hits at 30.
        add(1, 32'h1A, 1, 0, 0, 0, 0,   32'h30, 1, 0, 32'h1A, 32'h34, 1);
        add(1, 32'h1B, 1, 0, 0, 0, 0,   32'h30, 1, 0, 32'h1B, 32'h34, 1);
        add(1, 32'h1C, 0, 0, 0, 0, 0,   32'h30, 1, 0, 32'h1C, 32'h34, 1);
        // Redirect overwritten in DISCARD (branch 70 beats jump 90).
        add(0, 32'hDEAD, 0, 0, 0, 1, 32'h60, 32'h34, 0, 1, 32'h0, 0, 1);
        add(0, 32'hDEAD, 0, 1, 32'h70, 1, 32'h90, 32'h34, 0, 1, 32'h0, 0, 1);
        add(1, 32'hDEAD, 0, 0, 0, 0, 0, 32'h34, 0, 1, 32'h0, 0, 0);
        // Same-cycle redirect on DISCARD completion wins over pend_pc.
        add(0, 32'hDEAD, 0, 0, 0, 1, 32'h74, 32'h70, 0, 1, 32'h0, 0, 1);
        add(1, 32'hDEAD, 0, 0, 0, 1, 32'h200, 32'h70, 0, 1, 32'h0, 0, 0);
        // pc+4 wrap and unaligned target.
        add(1, 32'h1E, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h200, 1, 0, 32'h1E, 32'h204, 1);
        add(1, 32'h1F, 0, 0, 0, 0, 0,   32'hFFFF_FFFC, 1, 0, 32'h1F, 32'h0, 1);
        add(1, 32'h20, 0, 0, 0, 1, 32'h103, 32'h00, 1, 0, 32'h20, 32'h04, 1);
        add(1, 32'h21, 1, 0, 0, 1, 32'h50, 32'h100, 1, 0, 32'h21, 32'h107, 1);
        // Miss at 50 with stall asserted: request is held.
        add(0, 32'hDEAD, 1, 0, 0, 0, 0, 32'h50, 0, 1, 32'h0, 0, 1);
        add(0, 32'hDEAD, 0, 0, 0, 0, 0, 32'h50, 0, 1, 32'h0, 0, 1);

        // Reset state, with the cache claiming ready to prove outputs are gated.
        rst = 1'b0; stall = 0; branch_taken = 0; jump = 0;
        branch_target = 0; jump_target = 0; icache_ready = 1; icache_rdata = 32'hDEAD;
        #12;
        chk("rst req",  {31'd0, icache_req}, 32'd0);
        chk("rst vld",  {31'd0, if_valid}, 32'd0);
        chk("rst ms",   {31'd0, miss_stall}, 32'd0);
        chk("rst ins",  ins, 32'h0);
        chk("rst pc4",  pc_4, 32'h4);

        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #3;
            compare(i);
            @(posedge clk); #1;
        end

        // Reset mid-miss at 50.
        icache_ready = 0; stall = 0; jump = 0; branch_taken = 0;
        #2;
        chk("midmiss addr", icache_addr, 32'h50);
        chk("midmiss ms",   {31'd0, miss_stall}, 32'd1);
        rst = 1'b0;
        #1;
        chk("arst req", {31'd0, icache_req}, 32'd0);
        chk("arst vld", {31'd0, if_valid}, 32'd0);
        chk("arst ms",  {31'd0, miss_stall}, 32'd0);
        chk("arst ins", ins, 32'h0);
        chk("arst pc4", pc_4, 32'h4);
        icache_ready = 1; icache_rdata = 32'hBEEF;
        #1;
        chk("arst rdy vld", {31'd0, if_valid}, 32'd0);
        chk("arst rdy ins", ins, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        #3;
        chk("rel req",  {31'd0, icache_req}, 32'd1);
        chk("rel addr", icache_addr, 32'h0);
        chk("rel vld",  {31'd0, if_valid}, 32'd1);
        chk("rel ins",  ins, 32'hBEEF);
        chk("rel pc4",  pc_4, 32'h4);
        @(posedge clk); #4;
        chk("rel addr2", icache_addr, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
